clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Receive-side checker for divided clock/strobe waveforms, e.g. the clk10 output of a clock divider.
//  - Samples a single-bit waveform in the same fast clock domain and measures each period and high time.
//  - Compares both against expected values and reports lock, a sticky error and per-period measurements.
//  - Sits beside a divider instance as an on-chip health monitor.
// PARAMETERS
//  EXP_PERIOD  10  expected period, in clk cycles between rising edges of div_in
//  EXP_HIGH    4   expected number of cycles div_in is high per period
//  TOL         0   allowed absolute deviation, applied to both period and high time
//  LOCK_CNT    4   consecutive matching periods required to assert locked
//  CNT_W       8   counter/measurement width; require EXP_PERIOD+TOL < 2**CNT_W-1
// PORTS
//  clk         in   1      fast clock; all logic on its rising edge
//  rst         in   1      synchronous, active-high reset
//  enable      in   1      1 = monitor running; 0 = idle
//  div_in      in   1      monitored waveform; registered in the clk domain, so no synchroniser
//  err_clr     in   1      clears err (and err_cnt) on the next edge
//  period_o    out  CNT_W  period of last completed measurement
//  high_o      out  CNT_W  high-cycle count of last completed measurement
//  meas_valid  out  1      1-cycle pulse: period_o/high_o updated this cycle
//  locked      out  1      LOCK_CNT consecutive matches seen, no mismatch since
//  err         out  1      sticky: mismatch while locked, or timeout
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE; all counters, outputs and the delayed sample d_q are 0.
//  - Edges: rise = div_in & ~d_q, with d_q = div_in delayed by 1 clk.
//  - per_cnt: loads 1 on a rise cycle, +1 otherwise, saturates at 2**CNT_W-1.
//  - hi_cnt: loads 1 on a rise cycle, +1 while div_in=1, holds while div_in=0.
//  - Measurement = values of per_cnt and hi_cnt on a rise cycle: cycles since previous rise, and cycles sampled high (rise cycle included).
//  - States:
//    - IDLE: enable=1 -> WAIT_EDGE.
//    - WAIT_EDGE: first rise arms the counters -> MEASURE. No output on this rise.
//    - MEASURE: each rise produces a measurement.
//      - match -> good_cnt+1; good_cnt reaching LOCK_CNT -> LOCKED, locked=1.
//      - mismatch -> good_cnt=0; err unchanged.
//    - LOCKED: rise with mismatch -> err=1, locked=0, good_cnt=0, -> MEASURE.
//  - Match: |period-EXP_PERIOD| <= TOL and |high-EXP_HIGH| <= TOL. Compute in CNT_W+1 bits; no wrap.
//  - Latency: period_o, high_o, meas_valid and locked/err updates all register on the edge that ends the rise cycle (1 cycle).
//  - Timeout: per_cnt reaches 2**CNT_W-1 in MEASURE or LOCKED (stuck high or low).
//    - Effect: err=1, locked=0, good_cnt=0, -> WAIT_EDGE; no meas_valid.
//  - enable=0 in any state: -> IDLE next edge; locked=0; counters cleared.
//    - Held: period_o, high_o, err.
//    - A period cut short by enable=0 is never reported.
//  - err_clr: err=0 next edge. If err_clr and an error event occur in the same cycle, set wins.
//  - rst mid-measurement overrides everything; the waveform must be reacquired from WAIT_EDGE.
// CONFIGURATION
//  CLK_DIV_MON_ERRCNT_EN
//  - Defined: adds output err_cnt [7:0], a saturating (255) count of error events (mismatch-while-locked and timeout).
//    - Reset value 0; cleared by err_clr; if clear and event coincide, result is 1.
//  - Undefined: port and counter absent; all other behaviour identical.
// TESTING (defaults unless noted)
//  1. Ideal /10 waveform, 4 high, after rst:
//     - first meas_valid one cycle after the 2nd rise: period_o=10, high_o=4.
//     - locked=1 with the 4th meas_valid; err=0 throughout.
//  2. Locked; one period of 11 (high 4):
//     - meas_valid with period_o=11; locked=0 and err=1 in that same cycle.
//     - locked=1 again after 4 good periods; err stays 1 until err_clr.
//  3. Locked; div_in held 0:
//     - err=1 and locked=0 when per_cnt hits 255; no meas_valid.
//     - Next two rises relock the measurement path (WAIT_EDGE then MEASURE).
//  4. err_clr pulsed in the same cycle as a mismatch while locked -> err remains 1; a later lone err_clr -> err=0.
//  5. enable dropped mid-period while locked:
//     - next cycle locked=0; no meas_valid; period_o holds 10.
//     - After re-enable, the first rise produces no output.
//  6. CLK_DIV_MON_ERRCNT_EN:
//     - 3 injected mismatches while locked -> err_cnt=3.
//     - 300 error events -> err_cnt=255.
//     - err_clr -> err_cnt=0.

Source files
------------

// File: rtl/clk_div_monitor.sv
// Period/high-time checker for a divided clock or strobe sampled in the fast clk domain.
// Optional err_cnt output enabled by defining CLK_DIV_MON_ERRCNT_EN.
module clk_div_monitor #(
  parameter int unsigned EXP_PERIOD = 10,
  parameter int unsigned EXP_HIGH   = 4,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             div_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             locked,
  output logic             err
`ifdef CLK_DIV_MON_ERRCNT_EN
  ,
  output logic [7:0]       err_cnt
`endif
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam int unsigned      GoodW  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0]   ExpPer = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   ExpHi  = (CNT_W + 1)'(EXP_HIGH);
  localparam logic [CNT_W:0]   Tol    = (CNT_W + 1)'(TOL);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {StIdle, StWaitEdge, StMeasure, StLocked} state_e;

  state_e           state_q;
  logic             d_q;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_cnt;
  logic [GoodW-1:0] good_cnt;

  logic           rise;
  logic           active;
  logic           timeout;
  logic           match;
  logic           err_event;
  logic [CNT_W:0] per_ext;
  logic [CNT_W:0] hi_ext;
  logic [CNT_W:0] per_diff;
  logic [CNT_W:0] hi_diff;

  always_comb begin
    rise     = div_in & ~d_q;
    active   = enable && (state_q == StMeasure || state_q == StLocked);
    timeout  = active && (per_cnt == CntMax);
    per_ext  = {1'b0, per_cnt};
    hi_ext   = {1'b0, hi_cnt};
    per_diff = (per_ext >= ExpPer) ? per_ext - ExpPer : ExpPer - per_ext;
    hi_diff  = (hi_ext >= ExpHi) ? hi_ext - ExpHi : ExpHi - hi_ext;
    match    = (per_diff <= Tol) && (hi_diff <= Tol);
    err_event = timeout || (active && !timeout && rise && !match && state_q == StLocked);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      d_q        <= 1'b0;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      good_cnt   <= '0;
      period_o   <= '0;
      high_o     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
`ifdef CLK_DIV_MON_ERRCNT_EN
      err_cnt    <= 8'd0;
`endif
    end else begin
      d_q        <= div_in;
      meas_valid <= 1'b0;

      // Set wins over clear when both happen in one cycle.
      if (err_event) err <= 1'b1;
      else if (err_clr) err <= 1'b0;

`ifdef CLK_DIV_MON_ERRCNT_EN
      if (err_clr) err_cnt <= err_event ? 8'd1 : 8'd0;
      else if (err_event && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
`endif

      if (!enable) begin
        state_q  <= StIdle;
        locked   <= 1'b0;
        per_cnt  <= '0;
        hi_cnt   <= '0;
        good_cnt <= '0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StWaitEdge;
          StWaitEdge: begin
            if (rise) begin
              per_cnt <= CNT_W'(1);
              hi_cnt  <= CNT_W'(1);
              state_q <= StMeasure;
            end
          end
          StMeasure, StLocked: begin
            if (timeout) begin
              state_q  <= StWaitEdge;
              locked   <= 1'b0;
              good_cnt <= '0;
              per_cnt  <= '0;
              hi_cnt   <= '0;
            end else begin
              // per_cnt < CntMax here, so the increment cannot wrap.
              per_cnt <= rise ? CNT_W'(1) : per_cnt + 1'b1;
              if (rise) hi_cnt <= CNT_W'(1);
              else if (div_in && hi_cnt != CntMax) hi_cnt <= hi_cnt + 1'b1;

              if (rise) begin
                meas_valid <= 1'b1;
                period_o   <= per_cnt;
                high_o     <= hi_cnt;
                if (match) begin
                  if (state_q == StMeasure) begin
                    if (good_cnt == GoodLast) begin
                      state_q <= StLocked;
                      locked  <= 1'b1;
                    end else begin
                      good_cnt <= good_cnt + 1'b1;
                    end
                  end
                end else begin
                  good_cnt <= '0;
                  locked   <= 1'b0;
                  state_q  <= StMeasure;
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: table of waveform periods plus hand sequences for
// timeout, enable drop and (with CLK_DIV_MON_ERRCNT_EN) the error counter.
module tb_clk_div_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       div_in;
  logic       err_clr;
  logic [7:0] period_o;
  logic [7:0] high_o;
  logic       meas_valid;
  logic       locked;
  logic       err;
`ifdef CLK_DIV_MON_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Outputs captured right after the rise cycle of the most recent period() call.
  int snap_mv, snap_po, snap_ho, snap_lk, snap_er;

  clk_div_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .div_in     (div_in),
    .err_clr    (err_clr),
    .period_o   (period_o),
    .high_o     (high_o),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err)
`ifdef CLK_DIV_MON_ERRCNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int hi;
    bit clr;
    bit mv;
    int po;
    int ho;
    bit lk;
    bit er;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit d, input bit clr, input bit en);
    @(negedge clk);
    div_in  = d;
    err_clr = clr;
    enable  = en;
    @(posedge clk);
    #1;
  endtask

  // One waveform period starting with its rise cycle; err_clr optionally on the rise cycle.
  task automatic period(input int p, input int h, input bit clr);
    for (int i = 0; i < p; i++) begin
      drive(i < h, (i == 0) && clr, 1'b1);
      if (i == 0) begin
        snap_mv = int'(meas_valid);
        snap_po = int'(period_o);
        snap_ho = int'(high_o);
        snap_lk = int'(locked);
        snap_er = int'(err);
      end else begin
        chk("mv_quiet", int'(meas_valid), 0);
      end
    end
  endtask

  // Five good periods then one of 11: the 11 is reported while locked at the next rise.
  task automatic block();
    for (int i = 0; i < 5; i++) period(10, 4, 1'b0);
    period(11, 4, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    bit saw_mv;

    tbl[0]  = '{10, 4, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{10, 4, 0, 1, 10, 4, 0, 0};
    tbl[2]  = '{10, 4, 0, 1, 10, 4, 0, 0};
    tbl[3]  = '{10, 4, 0, 1, 10, 4, 0, 0};
    tbl[4]  = '{10, 4, 0, 1, 10, 4, 1, 0};
    tbl[5]  = '{11, 4, 0, 1, 10, 4, 1, 0};
    tbl[6]  = '{10, 4, 0, 1, 11, 4, 0, 1};
    tbl[7]  = '{10, 4, 0, 1, 10, 4, 0, 1};
    tbl[8]  = '{10, 4, 0, 1, 10, 4, 0, 1};
    tbl[9]  = '{10, 4, 0, 1, 10, 4, 0, 1};
    tbl[10] = '{10, 4, 0, 1, 10, 4, 1, 1};
    tbl[11] = '{ 9, 4, 1, 1, 10, 4, 1, 0};
    tbl[12] = '{10, 4, 1, 1,  9, 4, 0, 1};
    tbl[13] = '{10, 4, 1, 1, 10, 4, 0, 0};
    tbl[14] = '{10, 4, 0, 1, 10, 4, 0, 0};
    tbl[15] = '{10, 4, 0, 1, 10, 4, 0, 0};
    tbl[16] = '{10, 4, 0, 1, 10, 4, 1, 0};
    tbl[17] = '{10, 5, 0, 1, 10, 4, 1, 0};
    tbl[18] = '{10, 4, 0, 1, 10, 5, 0, 1};

    rst = 1'b1; enable = 1'b0; div_in = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period", int'(period_o), 0);
    chk("rst_high", int'(high_o), 0);
    chk("rst_mv", int'(meas_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
`ifdef CLK_DIV_MON_ERRCNT_EN
    chk("rst_err_cnt", int'(err_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    for (int v = 0; v < 19; v++) begin
      period(tbl[v].per, tbl[v].hi, tbl[v].clr);
      chk($sformatf("v%0d_mv", v), snap_mv, int'(tbl[v].mv));
      chk($sformatf("v%0d_period", v), snap_po, tbl[v].po);
      chk($sformatf("v%0d_high", v), snap_ho, tbl[v].ho);
      chk($sformatf("v%0d_locked", v), snap_lk, int'(tbl[v].lk));
      chk($sformatf("v%0d_err", v), snap_er, int'(tbl[v].er));
    end

    // Relock with err cleared, then hold div_in low until timeout.
    period(10, 4, 1'b1);
    chk("relock_err_clr", snap_er, 0);
    repeat (3) period(10, 4, 1'b0);
    chk("relock_locked", snap_lk, 1);
    drive(1'b1, 1'b0, 1'b1);
    first = 0;
    saw_mv = 1'b0;
    for (int k = 1; k <= 400 && first == 0; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (meas_valid) saw_mv = 1'b1;
      if (err) begin
        first = k;
        chk("timeout_locked", int'(locked), 0);
      end
    end
    chk("timeout_cycle", first, 255);
    chk("timeout_no_mv", int'(saw_mv), 0);
    period(10, 4, 1'b0);
    chk("reacq_first_rise_mv", snap_mv, 0);
    period(10, 4, 1'b0);
    chk("reacq_second_mv", snap_mv, 1);
    chk("reacq_period", snap_po, 10);
    chk("reacq_high", snap_ho, 4);
    chk("reacq_err_sticky", snap_er, 1);
    repeat (3) period(10, 4, 1'b0);
    chk("reacq_locked", snap_lk, 1);

    // Drop enable mid-period while locked.
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    chk("dis_locked", int'(locked), 0);
    chk("dis_mv", int'(meas_valid), 0);
    chk("dis_period_hold", int'(period_o), 10);
    chk("dis_err_hold", int'(err), 1);
    saw_mv = 1'b0;
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b0);
      if (meas_valid) saw_mv = 1'b1;
    end
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    if (meas_valid) saw_mv = 1'b1;
    chk("dis_no_mv", int'(saw_mv), 0);
    period(10, 4, 1'b0);
    chk("reen_first_rise_mv", snap_mv, 0);
    period(10, 4, 1'b0);
    chk("reen_second_mv", snap_mv, 1);
    chk("reen_period", snap_po, 10);

`ifdef CLK_DIV_MON_ERRCNT_EN
    period(10, 4, 1'b1);
    chk("cnt_clr_err", snap_er, 0);
    chk("cnt_clr", int'(err_cnt), 0);
    repeat (3) block();
    period(10, 4, 1'b0);
    chk("cnt_three", int'(err_cnt), 3);
    chk("cnt_three_err", int'(err), 1);
    repeat (297) block();
    period(10, 4, 1'b0);
    chk("cnt_saturate", int'(err_cnt), 255);
    block();
    period(10, 4, 1'b1);
    chk("cnt_clr_and_event", int'(err_cnt), 1);
    chk("cnt_clr_and_event_err", int'(err), 1);
    period(10, 4, 1'b1);
    chk("cnt_clr_lone", int'(err_cnt), 0);
    chk("cnt_clr_lone_err", int'(err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
